// File: rtl/fb_mem_arbiter_pkg.sv
// Shared widths, requester IDs and swap states for the framebuffer arbiter.
package fb_pkg;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 24;
    localparam int NUM_PIXELS = 307200;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_BLEND,
        REQ_DISP,
        REQ_CLEAR
    } req_id_e;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_e;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Blender, scanout, swap-control and SRAM-side signals of the framebuffer arbiter.
interface fb_mem_arbiter_if;
    import fb_pkg::*;

    logic              blend_req;
    logic              blend_we;
    logic [ADDR_W-1:0] blend_addr;
    logic [DATA_W-1:0] blend_wdata;
    logic              blend_grant;
    logic              blend_rvalid;
    logic [DATA_W-1:0] blend_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_grant;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              frame_ready;
    logic              disp_vsync;
    logic              o_frame_ready;
    logic              front_buf;

    logic [ADDR_W:0]   mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  blend_req, blend_we, blend_addr, blend_wdata,
        output blend_grant, blend_rvalid, blend_rdata,
        input  disp_req, disp_addr,
        output disp_grant, disp_rvalid, disp_rdata,
        input  frame_ready, disp_vsync,
        output o_frame_ready, front_buf,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output blend_req, blend_we, blend_addr, blend_wdata,
        input  blend_grant, blend_rvalid, blend_rdata,
        output disp_req, disp_addr,
        input  disp_grant, disp_rvalid, disp_rdata,
        output frame_ready, disp_vsync,
        input  o_frame_ready, front_buf,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Tracks which requester owns each outstanding SRAM read and steers the
// returning data to that requester's rvalid/rdata.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  req_id_e           tag_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              blend_rvalid,
    output logic [DATA_W-1:0] blend_rdata,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata
);

    // Stage 0 lines up with the registered mem_rd; the last stage with returning data.
    req_id_e tag_q [RD_LAT+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= REQ_NONE;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        blend_rvalid = (tag_q[RD_LAT] == REQ_BLEND);
        disp_rvalid  = (tag_q[RD_LAT] == REQ_DISP);
        blend_rdata  = blend_rvalid ? mem_rdata : '0;
        disp_rdata   = disp_rvalid  ? mem_rdata : '0;
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer SRAM arbiter with double-buffer swap control.
// Define FB_CLEAR_EN to add the post-swap back-buffer clear engine and clear_busy port.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
`ifdef FB_CLEAR_EN
    ,
    parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS
`endif
) (
    input  logic            clk,
    input  logic            reset,
    fb_mem_arbiter_if.slave bus
`ifdef FB_CLEAR_EN
    ,
    output logic            clear_busy
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    swap_state_e   swap_st;
    logic          front_q;
    logic          swap_pending;
    logic          swap_fire;
    logic          clear_act;
    logic          blend_elig;
    logic          slot_req;
    logic          starved;
    logic          slot_gnt;
    logic          disp_gnt;
    logic          blend_gnt;
    logic [SW-1:0] starve_cnt;
    req_id_e       tag_in;

    assign swap_pending  = (swap_st == SWAP_PENDING);
    assign swap_fire     = swap_pending && bus.disp_vsync;
    assign bus.front_buf = front_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_st           <= SWAP_IDLE;
            front_q           <= 1'b0;
            bus.o_frame_ready <= 1'b0;
        end else begin
            bus.o_frame_ready <= 1'b0;
            case (swap_st)
                SWAP_IDLE: begin
                    if (bus.frame_ready) begin
                        swap_st <= SWAP_PENDING;
                    end
                end
                SWAP_PENDING: begin
                    if (swap_fire) begin
                        swap_st           <= SWAP_IDLE;
                        front_q           <= ~front_q;
                        bus.o_frame_ready <= 1'b1;
                    end
                end
                default: swap_st <= SWAP_IDLE;
            endcase
        end
    end

`ifdef FB_CLEAR_EN
    logic              clear_q;
    logic              clear_gnt;
    logic [ADDR_W-1:0] clear_addr;

    assign clear_act  = clear_q;
    assign clear_busy = clear_q;
    assign clear_gnt  = slot_gnt && clear_q;

    // Each swap restarts the sweep over the freshly exposed back buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_q    <= 1'b0;
            clear_addr <= '0;
        end else if (swap_fire) begin
            clear_q    <= 1'b1;
            clear_addr <= '0;
        end else if (clear_gnt) begin
            if (clear_addr == ADDR_W'(NUM_PIXELS - 1)) begin
                clear_q <= 1'b0;
            end else begin
                clear_addr <= clear_addr + 1'b1;
            end
        end
    end
`else
    assign clear_act = 1'b0;
`endif

    // The clear engine, when running, owns the blender's slot and its starvation credit.
    always_comb begin
        blend_elig = bus.blend_req && !swap_pending && !clear_act;
        slot_req   = clear_act || blend_elig;
        starved    = slot_req && (starve_cnt == SW'(STARVE_MAX));
        slot_gnt   = 1'b0;
        disp_gnt   = 1'b0;
        if (starved) begin
            slot_gnt = 1'b1;
        end else if (bus.disp_req) begin
            disp_gnt = 1'b1;
        end else if (slot_req) begin
            slot_gnt = 1'b1;
        end
    end

    assign blend_gnt       = slot_gnt && !clear_act;
    assign bus.blend_grant = blend_gnt;
    assign bus.disp_grant  = disp_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!slot_req || slot_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // The buffer bit is frozen here, so a later swap cannot redirect an issued access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            if (disp_gnt) begin
                bus.mem_rd   <= 1'b1;
                bus.mem_addr <= {front_q, bus.disp_addr};
            end else if (blend_gnt) begin
                bus.mem_rd   <= !bus.blend_we;
                bus.mem_wr   <= bus.blend_we;
                bus.mem_addr <= {~front_q, bus.blend_addr};
                if (bus.blend_we) begin
                    bus.mem_wdata <= bus.blend_wdata;
                end
            end
`ifdef FB_CLEAR_EN
            else if (clear_gnt) begin
                bus.mem_wr    <= 1'b1;
                bus.mem_addr  <= {~front_q, clear_addr};
                bus.mem_wdata <= '0;
            end
`endif
        end
    end

    assign tag_in = disp_gnt ? REQ_DISP :
                    ((blend_gnt && !bus.blend_we) ? REQ_BLEND : REQ_NONE);

    fb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .reset        (reset),
        .tag_in       (tag_in),
        .mem_rdata    (bus.mem_rdata),
        .blend_rvalid (bus.blend_rvalid),
        .blend_rdata  (bus.blend_rdata),
        .disp_rvalid  (bus.disp_rvalid),
        .disp_rdata   (bus.disp_rdata)
    );

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter; with FB_CLEAR_EN defined it also covers the
// clear engine using a 16-pixel buffer.
module tb_fb_mem_arbiter;
    import fb_pkg::*;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 8;
`ifdef FB_CLEAR_EN
    localparam int NPIX       = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    int                checks = 0;
    int                passed = 0;
    logic [RD_LAT-1:0] rd_vld = '0;
    logic [DATA_W-1:0] rd_data [RD_LAT];

    fb_mem_arbiter_if bus ();

`ifdef FB_CLEAR_EN
    logic clear_busy;
    fb_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .NUM_PIXELS(NPIX)) dut (
        .clk(clk), .reset(reset), .bus(bus), .clear_busy(clear_busy));
`else
    fb_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Read-only SRAM contents seen by the tests; everything else reads as zero.
    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W:0] a);
        case (a)
            {1'b0, ADDR_W'(5)}:  sram_word = 24'h123456;
            {1'b1, ADDR_W'(20)}: sram_word = 24'hCAFE01;
            {1'b0, ADDR_W'(20)}: sram_word = 24'h0BAD00;
            default:             sram_word = '0;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_vld[0]  <= bus.mem_rd;
        rd_data[0] <= sram_word(bus.mem_addr);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_data[i] <= rd_data[i-1];
        end
    end
    assign bus.mem_rdata = rd_vld[RD_LAT-1] ? rd_data[RD_LAT-1] : '0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.blend_req   = 1'b0;
        bus.blend_we    = 1'b0;
        bus.blend_addr  = '0;
        bus.blend_wdata = '0;
        bus.disp_req    = 1'b0;
        bus.disp_addr   = '0;
        bus.frame_ready = 1'b0;
        bus.disp_vsync  = 1'b0;
    endtask

    task automatic settle_clear();
`ifdef FB_CLEAR_EN
        int n = 0;
        while (clear_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (clear_busy !== 1'b0) $display("[TB] FAIL clear_settle: clear_busy got %0b, want 0", clear_busy); else passed++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.front_buf !== 1'b0) $display("[TB] FAIL reset_front_buf: got %0b, want 0", bus.front_buf); else passed++;
        checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b, want 00", {bus.mem_rd, bus.mem_wr}); else passed++;
        checks++; if (bus.mem_addr !== '0) $display("[TB] FAIL reset_mem_addr: got %h, want 0", bus.mem_addr); else passed++;
        checks++; if (bus.mem_wdata !== '0) $display("[TB] FAIL reset_mem_wdata: got %h, want 0", bus.mem_wdata); else passed++;
        checks++; if ({bus.o_frame_ready, bus.blend_rvalid, bus.disp_rvalid} !== 3'b000) $display("[TB] FAIL reset_pulses: got %b, want 000", {bus.o_frame_ready, bus.blend_rvalid, bus.disp_rvalid}); else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_disp_read();
        bus.disp_req  = 1'b1;
        bus.disp_addr = ADDR_W'(5);
        #1;
        checks++; if (bus.disp_grant !== 1'b1) $display("[TB] FAIL disp_grant: got %0b, want 1", bus.disp_grant); else passed++;
        checks++; if (bus.blend_grant !== 1'b0) $display("[TB] FAIL disp_no_blend_grant: got %0b, want 0", bus.blend_grant); else passed++;
        step();
        bus.disp_req = 1'b0;
        #1;
        checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b10) $display("[TB] FAIL disp_issue_strobes: got %b, want 10", {bus.mem_rd, bus.mem_wr}); else passed++;
        checks++; if (bus.mem_addr !== {1'b0, ADDR_W'(5)}) $display("[TB] FAIL disp_issue_addr: got %h, want %h", bus.mem_addr, {1'b0, ADDR_W'(5)}); else passed++;
        repeat (RD_LAT - 1) begin
            step();
            #1;
            checks++; if ({bus.mem_rd, bus.disp_rvalid} !== 2'b00) $display("[TB] FAIL disp_wait: rd/rvalid got %b, want 00", {bus.mem_rd, bus.disp_rvalid}); else passed++;
        end
        step();
        #1;
        checks++; if (bus.disp_rvalid !== 1'b1) $display("[TB] FAIL disp_rvalid: got %0b, want 1", bus.disp_rvalid); else passed++;
        checks++; if (bus.disp_rdata !== 24'h123456) $display("[TB] FAIL disp_rdata: got %h, want 123456", bus.disp_rdata); else passed++;
        step();
        #1;
        checks++; if (bus.disp_rvalid !== 1'b0) $display("[TB] FAIL disp_rvalid_end: got %0b, want 0", bus.disp_rvalid); else passed++;
    endtask

    task automatic test_starvation();
        bus.blend_req   = 1'b1;
        bus.blend_we    = 1'b1;
        bus.blend_addr  = ADDR_W'(10);
        bus.blend_wdata = 24'hFF8000;
        bus.disp_req    = 1'b1;
        bus.disp_addr   = '0;
        for (int i = 1; i <= STARVE_MAX + 1; i++) begin
            #1;
            checks++; if (bus.blend_grant !== (i == STARVE_MAX + 1)) $display("[TB] FAIL starve_blend_grant cycle %0d: got %0b, want %0b", i, bus.blend_grant, (i == STARVE_MAX + 1)); else passed++;
            checks++; if (bus.disp_grant !== (i != STARVE_MAX + 1)) $display("[TB] FAIL starve_disp_grant cycle %0d: got %0b, want %0b", i, bus.disp_grant, (i != STARVE_MAX + 1)); else passed++;
            step();
        end
        bus.blend_req = 1'b0;
        bus.disp_req  = 1'b0;
        #1;
        checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b01) $display("[TB] FAIL starve_strobes: got %b, want 01", {bus.mem_rd, bus.mem_wr}); else passed++;
        checks++; if (bus.mem_addr !== {1'b1, ADDR_W'(10)}) $display("[TB] FAIL starve_addr: got %h, want %h", bus.mem_addr, {1'b1, ADDR_W'(10)}); else passed++;
        checks++; if (bus.mem_wdata !== 24'hFF8000) $display("[TB] FAIL starve_wdata: got %h, want ff8000", bus.mem_wdata); else passed++;
        repeat (RD_LAT + 2) step();
    endtask

    task automatic test_swap();
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        bus.blend_req   = 1'b1;
        bus.blend_we    = 1'b1;
        bus.blend_addr  = ADDR_W'(7);
        bus.blend_wdata = 24'h00ABCD;
        repeat (3) begin
            #1;
            checks++; if (bus.blend_grant !== 1'b0) $display("[TB] FAIL swap_pending_grant: got %0b, want 0", bus.blend_grant); else passed++;
            step();
        end
        bus.disp_vsync = 1'b1;
        #1;
        checks++; if ({bus.blend_grant, bus.front_buf} !== 2'b00) $display("[TB] FAIL swap_vsync_cycle: grant/front got %b, want 00", {bus.blend_grant, bus.front_buf}); else passed++;
        step();
        bus.disp_vsync = 1'b0;
        #1;
        checks++; if (bus.front_buf !== 1'b1) $display("[TB] FAIL swap_front_buf: got %0b, want 1", bus.front_buf); else passed++;
        checks++; if (bus.o_frame_ready !== 1'b1) $display("[TB] FAIL swap_o_frame_ready: got %0b, want 1", bus.o_frame_ready); else passed++;
`ifdef FB_CLEAR_EN
        checks++; if ({clear_busy, bus.blend_grant} !== 2'b10) $display("[TB] FAIL swap_clear_start: busy/grant got %b, want 10", {clear_busy, bus.blend_grant}); else passed++;
        step();
        #1;
        checks++; if (bus.o_frame_ready !== 1'b0) $display("[TB] FAIL swap_o_frame_ready_end: got %0b, want 0", bus.o_frame_ready); else passed++;
        begin
            int n = 0;
            while (bus.blend_grant !== 1'b1 && n < 64) begin
                step();
                #1;
                n++;
            end
            checks++; if (n !== NPIX - 1) $display("[TB] FAIL swap_clear_wait: blend granted after %0d cycles, want %0d", n, NPIX - 1); else passed++;
        end
        step();
        bus.blend_req = 1'b0;
        #1;
`else
        checks++; if (bus.blend_grant !== 1'b1) $display("[TB] FAIL swap_blend_grant: got %0b, want 1", bus.blend_grant); else passed++;
        step();
        bus.blend_req = 1'b0;
        #1;
        checks++; if (bus.o_frame_ready !== 1'b0) $display("[TB] FAIL swap_o_frame_ready_end: got %0b, want 0", bus.o_frame_ready); else passed++;
`endif
        checks++; if (bus.mem_wr !== 1'b1) $display("[TB] FAIL swap_mem_wr: got %0b, want 1", bus.mem_wr); else passed++;
        checks++; if (bus.mem_addr !== {1'b0, ADDR_W'(7)}) $display("[TB] FAIL swap_mem_addr: got %h, want %h", bus.mem_addr, {1'b0, ADDR_W'(7)}); else passed++;
        checks++; if (bus.mem_wdata !== 24'h00ABCD) $display("[TB] FAIL swap_mem_wdata: got %h, want 00abcd", bus.mem_wdata); else passed++;
        step();
    endtask

    task automatic test_same_cycle();
        bus.frame_ready = 1'b1;
        bus.disp_vsync  = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        bus.disp_vsync  = 1'b0;
        bus.blend_req   = 1'b1;
        bus.blend_we    = 1'b1;
        bus.blend_addr  = ADDR_W'(1);
        bus.blend_wdata = '0;
        #1;
        checks++; if ({bus.front_buf, bus.o_frame_ready} !== 2'b10) $display("[TB] FAIL same_cycle_no_swap: front/ofr got %b, want 10", {bus.front_buf, bus.o_frame_ready}); else passed++;
        checks++; if (bus.blend_grant !== 1'b0) $display("[TB] FAIL same_cycle_pending: blend_grant got %0b, want 0", bus.blend_grant); else passed++;
        step();
        bus.blend_req  = 1'b0;
        bus.disp_vsync = 1'b1;
        #1;
        checks++; if (bus.front_buf !== 1'b1) $display("[TB] FAIL same_cycle_hold: front_buf got %0b, want 1", bus.front_buf); else passed++;
        step();
        bus.disp_vsync = 1'b0;
        #1;
        checks++; if ({bus.front_buf, bus.o_frame_ready} !== 2'b01) $display("[TB] FAIL same_cycle_swap: front/ofr got %b, want 01", {bus.front_buf, bus.o_frame_ready}); else passed++;
        settle_clear();
    endtask

    task automatic test_inflight();
        bus.blend_req   = 1'b1;
        bus.blend_we    = 1'b0;
        bus.blend_addr  = ADDR_W'(20);
        bus.frame_ready = 1'b1;
        #1;
        checks++; if (bus.blend_grant !== 1'b1) $display("[TB] FAIL inflight_grant: got %0b, want 1", bus.blend_grant); else passed++;
        step();
        bus.blend_req   = 1'b0;
        bus.frame_ready = 1'b0;
        bus.disp_vsync  = 1'b1;
        #1;
        checks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 1'b1, ADDR_W'(20)}) $display("[TB] FAIL inflight_issue: rd/addr got %b/%h, want 1/%h", bus.mem_rd, bus.mem_addr, {1'b1, ADDR_W'(20)}); else passed++;
        step();
        bus.disp_vsync = 1'b0;
        #1;
        checks++; if ({bus.front_buf, bus.blend_rvalid} !== 2'b10) $display("[TB] FAIL inflight_swapped: front/rvalid got %b, want 10", {bus.front_buf, bus.blend_rvalid}); else passed++;
        step();
        #1;
        checks++; if ({bus.blend_rvalid, bus.disp_rvalid} !== 2'b10) $display("[TB] FAIL inflight_route: blend/disp rvalid got %b, want 10", {bus.blend_rvalid, bus.disp_rvalid}); else passed++;
        checks++; if (bus.blend_rdata !== 24'hCAFE01) $display("[TB] FAIL inflight_rdata: got %h, want cafe01", bus.blend_rdata); else passed++;
        step();
        #1;
        checks++; if (bus.blend_rvalid !== 1'b0) $display("[TB] FAIL inflight_rvalid_end: got %0b, want 0", bus.blend_rvalid); else passed++;
        settle_clear();
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        bus.disp_vsync  = 1'b1;
        step();
        bus.disp_vsync  = 1'b0;
        bus.blend_req   = 1'b1;
        bus.blend_we    = 1'b1;
        bus.blend_addr  = ADDR_W'(2);
        bus.blend_wdata = 24'h111111;
        #1;
        checks++; if ({clear_busy, bus.front_buf} !== 2'b10) $display("[TB] FAIL clear_start: busy/front got %b, want 10", {clear_busy, bus.front_buf}); else passed++;
        for (int k = 0; k < NPIX; k++) begin
            checks++; if (bus.blend_grant !== 1'b0) $display("[TB] FAIL clear_blend_blocked %0d: got %0b, want 0", k, bus.blend_grant); else passed++;
            step();
            #1;
            checks++; if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, ADDR_W'(k), DATA_W'(0)}) $display("[TB] FAIL clear_write %0d: wr/addr/data got %b/%h/%h, want 1/%h/0", k, bus.mem_wr, bus.mem_addr, bus.mem_wdata, {1'b1, ADDR_W'(k)}); else passed++;
        end
        checks++; if ({clear_busy, bus.blend_grant} !== 2'b01) $display("[TB] FAIL clear_done: busy/grant got %b, want 01", {clear_busy, bus.blend_grant}); else passed++;
        step();
        bus.blend_req = 1'b0;
        #1;
        checks++; if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, ADDR_W'(2), 24'h111111}) $display("[TB] FAIL clear_blend_write: wr/addr/data got %b/%h/%h", bus.mem_wr, bus.mem_addr, bus.mem_wdata); else passed++;
        step();
    endtask
`endif

    task automatic test_reset_midflight();
        bus.disp_req  = 1'b1;
        bus.disp_addr = ADDR_W'(5);
        step();
        bus.disp_req = 1'b0;
        reset        = 1'b0;
        #1;
        checks++; if ({bus.mem_rd, bus.front_buf} !== 2'b00) $display("[TB] FAIL midreset_clear: rd/front got %b, want 00", {bus.mem_rd, bus.front_buf}); else passed++;
        step();
        reset = 1'b1;
        repeat (RD_LAT + 2) begin
            #1;
            checks++; if ({bus.disp_rvalid, bus.blend_rvalid} !== 2'b00) $display("[TB] FAIL midreset_rvalid: got %b, want 00", {bus.disp_rvalid, bus.blend_rvalid}); else passed++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_disp_read();
        test_starvation();
        test_swap();
        test_same_cycle();
        test_inflight();
`ifdef FB_CLEAR_EN
        test_clear();
`endif
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
